// File: rtl/game_pkg.sv
// Shared constants for the tron timing/display block: active-low segment
// patterns ordered {g,f,e,d,c,b,a} and the default 50 MHz divisors.
package game_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam int DEFAULT_FAST_DIV = 2500000;
    localparam int DEFAULT_SEC_DIV  = 50000000;

endpackage

// File: rtl/hex_to_7seg.sv
// Purely combinational 4-bit digit to active-low 7-segment decoder.
module hex_to_7seg
    import game_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/game_timer_display.sv
// Movement-tick divider, MM:SS elapsed timer and score digits for the
// two-player tron game; every HEX output goes through hex_to_7seg.
module game_timer_display
    import game_pkg::*;
#(
    parameter int FAST_DIV = DEFAULT_FAST_DIV,
    parameter int SEC_DIV  = DEFAULT_SEC_DIV
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       enable,
    input  logic [3:0] p1_score,
    input  logic [3:0] p2_score,
    output logic       tick_fast,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX6
);

    localparam int FW = $clog2(FAST_DIV);
    localparam int SW = $clog2(SEC_DIV);
    localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(SEC_DIV - 1);

    logic [FW-1:0] fcnt;
    logic [SW-1:0] scnt;
    logic          sec_tick;
    logic [3:0]    s0, s1, m0, m1;

    // The timer advances on the same edge that wraps the prescaler.
    assign sec_tick = enable && (scnt == SEC_LAST);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            fcnt      <= '0;
            scnt      <= '0;
            tick_fast <= 1'b0;
        end else if (enable) begin
            fcnt      <= (fcnt == FAST_LAST) ? '0 : fcnt + 1'b1;
            scnt      <= (scnt == SEC_LAST)  ? '0 : scnt + 1'b1;
            tick_fast <= (fcnt == FAST_LAST);
        end else begin
            tick_fast <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            s0 <= '0;
            s1 <= '0;
            m0 <= '0;
            m1 <= '0;
        end else if (sec_tick) begin
            if (s0 != 4'd9) begin
                s0 <= s0 + 4'd1;
            end else begin
                s0 <= '0;
                if (s1 != 4'd5) begin
                    s1 <= s1 + 4'd1;
                end else begin
                    s1 <= '0;
                    if (m0 != 4'd9) begin
                        m0 <= m0 + 4'd1;
                    end else begin
                        m0 <= '0;
                        m1 <= (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
                    end
                end
            end
        end
    end

    hex_to_7seg u_hex0 (.digit(s0),       .seg(HEX0));
    hex_to_7seg u_hex1 (.digit(s1),       .seg(HEX1));
    hex_to_7seg u_hex2 (.digit(m0),       .seg(HEX2));
    hex_to_7seg u_hex3 (.digit(m1),       .seg(HEX3));
    hex_to_7seg u_hex4 (.digit(p1_score), .seg(HEX4));
    hex_to_7seg u_hex6 (.digit(p2_score), .seg(HEX6));

endmodule

// File: tb/tb_game_timer_display.sv
// Scoreboard bench for game_timer_display: the stimulus side pushes the
// expected outputs from an elapsed-count model, a monitor pops and compares.
module tb_game_timer_display;

    localparam int FAST_DIV = 4;
    localparam int SEC_DIV  = 10;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       enable   = 1'b0;
    logic [3:0] p1_score = 4'h0;
    logic [3:0] p2_score = 4'h0;
    logic       tick_fast;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX6;

    game_timer_display #(.FAST_DIV(FAST_DIV), .SEC_DIV(SEC_DIV)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .enable   (enable),
        .p1_score (p1_score),
        .p2_score (p2_score),
        .tick_fast(tick_fast),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX6     (HEX6)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic       tick;
        logic [6:0] h3, h2, h1, h0, h4, h6;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Model state: number of enabled edges since the last reset.
    int   fast_n = 0;
    int   sec_n  = 0;
    logic model_tick = 1'b0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int secs, mm, ss;
        secs   = (sec_n / SEC_DIV) % 6000;
        ss     = secs % 60;
        mm     = secs / 60;
        e.tick = model_tick;
        e.h0   = seg_of(ss % 10);
        e.h1   = seg_of(ss / 10);
        e.h2   = seg_of(mm % 10);
        e.h3   = seg_of(mm / 10);
        e.h4   = seg_of(int'(p1_score));
        e.h6   = seg_of(int'(p2_score));
        return e;
    endfunction

    task automatic cycle(input logic en, input logic rn, input logic [3:0] a, input logic [3:0] b);
        @(negedge CLOCK_50);
        #1;
        enable   = en;
        resetn   = rn;
        p1_score = a;
        p2_score = b;
        @(posedge CLOCK_50);
        if (!resetn) begin
            fast_n     = 0;
            sec_n      = 0;
            model_tick = 1'b0;
        end else if (enable) begin
            fast_n++;
            sec_n++;
            model_tick = (fast_n % FAST_DIV == 0);
        end else begin
            model_tick = 1'b0;
        end
        sbq.push_back(model_out());
    endtask

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(15, 0));
    endfunction

    task automatic async_reset();
        @(negedge CLOCK_50);
        #3;
        resetn     = 1'b0;
        fast_n     = 0;
        sec_n      = 0;
        model_tick = 1'b0;
        #1;
        chk("rst_tick", 32'(tick_fast), 32'd0);
        chk("rst_time", 32'({HEX3, HEX2, HEX1, HEX0}), 32'({4{7'b1000000}}));
    endtask

    task automatic check_time(input string name, input int m1, input int m0, input int s1, input int s0);
        #2;
        chk(name, 32'({HEX3, HEX2, HEX1, HEX0}),
            32'({seg_of(m1), seg_of(m0), seg_of(s1), seg_of(s0)}));
    endtask

    always @(negedge CLOCK_50) begin
        if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("tick_fast", 32'(tick_fast), 32'(mon_e.tick));
            chk("mmss", 32'({HEX3, HEX2, HEX1, HEX0}),
                32'({mon_e.h3, mon_e.h2, mon_e.h1, mon_e.h0}));
            chk("hex4", 32'(HEX4), 32'(mon_e.h4));
            chk("hex6", 32'(HEX6), 32'(mon_e.h6));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Decoder sweep, first p1 under reset, then p2 out of reset.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 4'(i), rnd4());
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, rnd4(), 4'(i));

        // Fast tick, uninterrupted then with enable dropped on cycles 6..8.
        async_reset();
        cycle(1'b0, 1'b0, rnd4(), rnd4());
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 1'b1, rnd4(), rnd4());
            #2;
            chk("tick_run", 32'(tick_fast), 32'(i == 4 || i == 8 || i == 12));
        end
        async_reset();
        cycle(1'b0, 1'b0, rnd4(), rnd4());
        for (int i = 1; i <= 14; i++) begin
            cycle(!(i >= 6 && i <= 8), 1'b1, rnd4(), rnd4());
            #2;
            chk("tick_pause", 32'(tick_fast), 32'(i == 4 || i == 11));
        end

        // Reset mid-count, then a long disabled stretch must not move anything.
        for (int i = 0; i < 237; i++) cycle(1'b1, 1'b1, rnd4(), rnd4());
        async_reset();
        cycle(1'b1, 1'b0, rnd4(), rnd4());
        cycle(1'b1, 1'b0, rnd4(), rnd4());
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, rnd4(), rnd4());
        check_time("hold_after_reset", 0, 0, 0, 0);
        chk("hold_tick", 32'(tick_fast), 32'd0);

        // Random enable with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399, 0) == 0) begin
                async_reset();
                for (int k = 0; k <= int'($urandom_range(2, 0)); k++)
                    cycle($urandom_range(1, 0) == 1, 1'b0, rnd4(), rnd4());
            end
            cycle($urandom_range(3, 0) != 0, 1'b1, rnd4(), rnd4());
        end

        // Reset at 00:37 with the prescaler part way through a second.
        async_reset();
        cycle(1'b1, 1'b0, rnd4(), rnd4());
        for (int i = 0; i < 374; i++) cycle(1'b1, 1'b1, rnd4(), rnd4());
        check_time("at_00_37", 0, 0, 3, 7);
        async_reset();
        cycle(1'b1, 1'b0, rnd4(), rnd4());
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1'b1, rnd4(), rnd4());
            if (i == 9)  check_time("before_first_inc", 0, 0, 0, 0);
            if (i == 10) check_time("first_inc", 0, 0, 0, 1);
        end

        // Rollovers and the 99:59 wrap.
        async_reset();
        cycle(1'b1, 1'b0, rnd4(), rnd4());
        for (int n = 1; n <= 60000; n++) begin
            cycle(1'b1, 1'b1, rnd4(), rnd4());
            if (n == 590)   check_time("at_00_59", 0, 0, 5, 9);
            if (n == 600)   check_time("at_01_00", 0, 1, 0, 0);
            if (n == 6000)  check_time("at_10_00", 1, 0, 0, 0);
            if (n == 59990) check_time("at_99_59", 9, 9, 5, 9);
            if (n == 60000) check_time("wrap_00_00", 0, 0, 0, 0);
        end

        @(negedge CLOCK_50);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
